csr_access_arbiter: RTL and testbench
=====================================

// Module: csr_access_arbiter
// PURPOSE
// - Shares one register-bank access port (RW/RO register array + address decoder) between NUM_REQ requesters.
//   Requesters include the SW bridge and HW engines.
// - Round-robin grant, one transaction in flight; issues a single write/read strobe, waits for the bank ACK, returns data.
// - Timeout protection: a bank that never ACKs completes the transaction with an error flag instead of hanging the bus.
// PARAMETERS
// - NUM_REQ     4   number of requesters (>=2)
// - ADDR_WIDTH  8   register address width
// - DATA_WIDTH  32  register data width
// - TIMEOUT     15  max cycles waiting for REG_ACK after strobe (>=1)
// PORTS
// - CLK        in   1                   clock, all logic on rising edge
// - RST        in   1                   synchronous active-high reset
// - REQ_VALID  in   NUM_REQ             per-requester access request, held until REQ_DONE
// - REQ_WRITE  in   NUM_REQ             1=write, 0=read
// - REQ_ADDR   in   NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
// - REQ_WDATA  in   NUM_REQ*DATA_WIDTH  packed write data
// - REQ_DONE   out  NUM_REQ             one-hot, 1-cycle completion pulse
// - RSP_RDATA  out  DATA_WIDTH          read data, valid while REQ_DONE!=0 (0 for writes/errors)
// - RSP_ERR    out  1                   timeout flag, valid while REQ_DONE!=0
// - REG_WEN    out  1                   1-cycle write strobe to bank
// - REG_REN    out  1                   1-cycle read strobe to bank
// - REG_ADDR   out  ADDR_WIDTH          latched address, stable from strobe until completion
// - REG_WDATA  out  DATA_WIDTH          latched write data, stable from strobe until completion
// - REG_RDATA  in   DATA_WIDTH          bank read data, sampled on REG_ACK
// - REG_ACK    in   1                   bank completion, accepted in ISSUE or WAIT
// BEHAVIOUR
// - Reset (RST=1 at edge):
//   - all outputs 0; state IDLE; timeout counter 0.
//   - last-grant pointer = NUM_REQ-1, so requester 0 wins first.
// - FSM states: IDLE, ISSUE, WAIT, DONE.
//   - IDLE: if any REQ_VALID, grant the first valid index searching from (ptr+1) mod NUM_REQ upward with wrap.
//     - Latch grant index, REQ_WRITE, REQ_ADDR, REQ_WDATA of the winner; ptr <= winner; go ISSUE.
//     - If none valid, stay IDLE.
//   - ISSUE: REG_WEN (write) or REG_REN (read) high for exactly this cycle; counter cleared.
//     - REG_ACK high this cycle -> DONE, else WAIT.
//   - WAIT: strobes low.
//     - REG_ACK -> DONE; capture REG_RDATA if read.
//     - Else counter++; counter==TIMEOUT-1 without ACK -> DONE with err=1.
//   - DONE: REQ_DONE[idx]=1, RSP_RDATA/RSP_ERR driven for this cycle only; next state IDLE.
// - Latency: VALID seen in IDLE at cycle 0 -> strobe cycle 1 -> REQ_DONE cycle 2 minimum.
//   Worst case 2+TIMEOUT cycles.
// - Arbitration updates only in IDLE; requests arriving mid-transaction wait. No starvation: max wait is NUM_REQ-1 transactions.
// - Requester dropping REQ_VALID after grant: transaction still completes and REQ_DONE still pulses (no abort).
// - Payload changes after grant are ignored (latched).
// - REG_ACK in IDLE or DONE: ignored. A late ACK after timeout is discarded.
// - Same requester re-requests right after DONE: it is eligible, but the pointer gives others priority first.
// - Reset mid-transaction: immediate return to IDLE; no REQ_DONE pulse; strobes low next cycle.
// - Widths: counter $clog2(TIMEOUT+1) bits; index $clog2(NUM_REQ) bits; no arithmetic overflow beyond wrap on ptr.
// STRUCTURE
// - Package csr_arb_pkg:
//   - state enum {IDLE, ISSUE, WAIT, DONE} (2 bits).
//   - functions idx_width(n) and cnt_width(t) wrapping $clog2.
// - Sub-module rr_pick:
//   - combinational rotate-priority-rotate back.
//   - inputs: req vector, last ptr. Outputs: any, winner index.
// - Top: FSM, payload latches, timeout counter, response registers.
// TESTING
// - Single req0 read, bank ACK in ISSUE with RDATA=0xA5A5_0001 -> REQ_DONE=0001 at cycle 2, RSP_RDATA=0xA5A5_0001, ERR=0.
// - REQ_VALID=1111 all held, zero-wait bank -> grant order 0,1,2,3,0; REQ_DONE one-hot each 3 cycles.
// - Req2 write addr 0x10 data 0xDEAD_BEEF, ACK 3 cycles after strobe:
//   - REG_WEN exactly one cycle; ADDR/WDATA stable until DONE.
//   - REQ_DONE=0100; RSP_RDATA=0.
// - Bank never ACKs, TIMEOUT=15 -> REQ_DONE with RSP_ERR=1 at cycle 2+15.
//   - A late ACK the next cycle is ignored; the next request proceeds normally.
// - RST asserted in WAIT -> no REQ_DONE; all outputs 0 next cycle.
//   - After reset, req0 and req3 both valid -> req0 granted first.
// - Req1 drops VALID and changes ADDR after grant -> bank sees the original ADDR; REQ_DONE[1] still pulses.

Source files
------------

// File: rtl/csr_access_arbiter_pkg.sv
// Shared types and width helpers for the CSR access arbiter.
package csr_arb_pkg;

  // Transaction phases: wait for a request, strobe the bank, wait for its ACK, report back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits needed to index n requesters (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count up to t inclusive.
  function automatic int cnt_width(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/csr_access_arbiter_rr_pick.sv
// Round-robin picker: rotate the request vector so the slot after the last
// grant sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_pick
  import csr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [idx_width(NUM_REQ)-1:0] ptr,
  output logic                          any,
  output logic [idx_width(NUM_REQ)-1:0] win
);

  localparam int IW  = idx_width(NUM_REQ);
  localparam int IW1 = IW + 1;
  localparam int N2  = 2 * NUM_REQ;

  logic [N2-1:0]      dbl;
  logic [NUM_REQ-1:0] rot;
  logic [IW1-1:0]     start;
  logic [IW1-1:0]     k;
  logic [IW1-1:0]     sum;

  // Rotate, find the lowest requesting slot, and map it back to a requester index.
  always_comb begin
    start = (ptr == IW'(NUM_REQ - 1)) ? '0 : ({1'b0, ptr} + IW1'(1));
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> start);
    any   = |rot;
    k     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) k = IW1'(i);
    end
    sum = start + k;
    win = IW'((sum >= IW1'(NUM_REQ)) ? (sum - IW1'(NUM_REQ)) : sum);
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// Shares one register-bank port between NUM_REQ requesters: round-robin grant,
// one transaction in flight, single-cycle strobe, ACK wait with timeout.
//
// Handshake: a requester raises REQ_VALID[i] with its payload and holds it
// until REQ_DONE[i] pulses for one cycle; the payload is latched at grant, so
// later changes (including dropping REQ_VALID) do not affect the transaction.
// On the bank side REG_WEN/REG_REN pulse for one cycle; REG_ACK is honoured
// only in the strobe cycle or while waiting and is ignored otherwise.
module csr_access_arbiter
  import csr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [NUM_REQ-1:0]               REQ_VALID,
  input  logic [NUM_REQ-1:0]               REQ_WRITE,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    REQ_ADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    REQ_WDATA,
  output logic [NUM_REQ-1:0]               REQ_DONE,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA,
  output logic                             RSP_ERR,
  output logic                             REG_WEN,
  output logic                             REG_REN,
  output logic [ADDR_WIDTH-1:0]            REG_ADDR,
  output logic [DATA_WIDTH-1:0]            REG_WDATA,
  input  logic [DATA_WIDTH-1:0]            REG_RDATA,
  input  logic                             REG_ACK,
  output state_t                           dbg_state
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(TIMEOUT);

  state_t                state_q, state_nxt;
  logic [IW-1:0]         ptr_q;
  logic [IW-1:0]         idx_q;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [CW-1:0]         cnt_q;

  logic                  pick_any;
  logic [IW-1:0]         pick_win;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = REQ_WDATA[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  logic timed_out;
  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state decode and output generation from the current phase.
  always_comb begin
    state_nxt = state_q;
    REG_WEN   = 1'b0;
    REG_REN   = 1'b0;
    REQ_DONE  = '0;
    RSP_RDATA = '0;
    RSP_ERR   = 1'b0;
    unique case (state_q)
      IDLE:  if (pick_any) state_nxt = ISSUE;
      ISSUE: begin
        REG_WEN   = wr_q;
        REG_REN   = ~wr_q;
        state_nxt = REG_ACK ? DONE : WAIT;
      end
      WAIT:  if (REG_ACK || timed_out) state_nxt = DONE;
      DONE: begin
        REQ_DONE[idx_q] = 1'b1;
        RSP_RDATA       = rdata_q;
        RSP_ERR         = err_q;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign REG_ADDR  = addr_q;
  assign REG_WDATA = wdata_q;
  assign dbg_state = state_q;

  // Grant latch, timeout counter and response capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q   <= IW'(NUM_REQ - 1);
      idx_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            idx_q   <= pick_win;
            ptr_q   <= pick_win;
            wr_q    <= REQ_WRITE[pick_win];
            addr_q  <= addr_arr[pick_win];
            wdata_q <= wdata_arr[pick_win];
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        ISSUE: begin
          cnt_q <= '0;
          if (REG_ACK && !wr_q) rdata_q <= REG_RDATA;
        end
        WAIT: begin
          if (REG_ACK) begin
            if (!wr_q) rdata_q <= REG_RDATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (timed_out) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Directed bench for csr_access_arbiter with a transaction-level reference model.
module tb_csr_access_arbiter;
  import csr_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 15;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NR-1:0]    REQ_VALID;
  logic [NR-1:0]    REQ_WRITE;
  logic [NR*AW-1:0] REQ_ADDR;
  logic [NR*DW-1:0] REQ_WDATA;
  logic [NR-1:0]    REQ_DONE;
  logic [DW-1:0]    RSP_RDATA;
  logic             RSP_ERR;
  logic             REG_WEN;
  logic             REG_REN;
  logic [AW-1:0]    REG_ADDR;
  logic [DW-1:0]    REG_WDATA;
  logic [DW-1:0]    REG_RDATA;
  logic             REG_ACK;
  state_t           dbg_state;

  csr_access_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_DONE(REQ_DONE),
    .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .REG_WEN(REG_WEN), .REG_REN(REG_REN),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_RDATA(REG_RDATA),
    .REG_ACK(REG_ACK), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- bank model ----------------
  // ack_delay: 0 = ACK in strobe cycle, d>0 = d cycles after strobe, <0 = never.
  int          ack_delay;
  logic [DW-1:0] bank_rdata;
  logic        inject_ack;
  int          bank_phase = -1;
  assign REG_RDATA = bank_rdata;
  assign REG_ACK = inject_ack |
                   ((REG_WEN | REG_REN) ? (ack_delay == 0)
                                        : (bank_phase >= 1 && bank_phase == ack_delay));
  always @(posedge CLK) begin
    if (RST || REG_ACK)           bank_phase <= -1;
    else if (REG_WEN || REG_REN)  bank_phase <= 1;
    else if (bank_phase >= 1)     bank_phase <= bank_phase + 1;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [NR-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            armed = 0;
  bit            m_busy = 0;
  int            m_ptr, m_idx, m_strobe, m_done, m_w;
  bit            m_wr, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [NR-1:0] e_done;
  bit            e_strobe;

  // Compare every cycle, then advance the model with this cycle's inputs.
  always @(negedge CLK) begin
    if (armed) begin
      e_strobe = m_busy && (cyc == m_strobe);
      e_done   = (m_busy && cyc == m_done) ? (NR'(1) << m_idx) : '0;
      chk("reg_wen",   REG_WEN,   e_strobe && m_wr);
      chk("reg_ren",   REG_REN,   e_strobe && !m_wr);
      chk("req_done",  REQ_DONE,  e_done);
      chk("rsp_rdata", RSP_RDATA, (e_done != 0) ? m_rdata : '0);
      chk("rsp_err",   RSP_ERR,   (e_done != 0) && m_err);
      chk("reg_addr",  REG_ADDR,  m_addr);
      chk("reg_wdata", REG_WDATA, m_wdata);
    end
    if (RST) begin
      armed   = 1;
      m_busy  = 0;
      m_ptr   = NR - 1;
      m_addr  = '0;
      m_wdata = '0;
    end else if (armed) begin
      if (m_busy && cyc == m_done) begin
        m_busy = 0;
      end else if (!m_busy) begin
        m_w = -1;
        for (int k = 1; k <= NR; k++)
          if (m_w < 0 && REQ_VALID[(m_ptr + k) % NR]) m_w = (m_ptr + k) % NR;
        if (m_w >= 0) begin
          m_busy   = 1;
          m_idx    = m_w;
          m_ptr    = m_w;
          m_wr     = REQ_WRITE[m_w];
          m_addr   = REQ_ADDR[m_w*AW +: AW];
          m_wdata  = REQ_WDATA[m_w*DW +: DW];
          m_strobe = cyc + 1;
          if (ack_delay >= 0 && ack_delay <= TO) begin
            m_done  = cyc + 2 + ack_delay;
            m_err   = 0;
            m_rdata = m_wr ? '0 : bank_rdata;
          end else begin
            m_done  = cyc + 2 + TO;
            m_err   = 1;
            m_rdata = '0;
          end
        end
      end
    end
  end

  int wen_total = 0;
  always @(negedge CLK) if (REG_WEN === 1'b1) wen_total <= wen_total + 1;

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    REQ_VALID = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_VALID[i] = 1'b1;
    REQ_WRITE[i] = wr;
    REQ_ADDR[i*AW +: AW] = a;
    REQ_WDATA[i*DW +: DW] = d;
  endtask

  // Wait (bounded) for the next completion pulse and pin it to literal values.
  task automatic expect_done(input string nm, input int want_cyc, input logic [DW-1:0] want_rd,
                             input logic want_err, input logic [AW-1:0] want_addr);
    bit seen = 0;
    logic [NR-1:0] want_done;
    want_done = exp_q.pop_front();
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge CLK);
      if (REQ_DONE != '0) begin
        seen = 1;
        chk({nm, "_cycle"}, 64'(cyc), 64'(want_cyc));
        chk({nm, "_onehot"}, REQ_DONE, want_done);
        chk({nm, "_rdata"}, RSP_RDATA, want_rd);
        chk({nm, "_err"}, RSP_ERR, want_err);
        chk({nm, "_addr"}, REG_ADDR, want_addr);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout cyc=%0d got=no REQ_DONE want=pulse at %0d", nm, cyc, want_cyc);
    end
  endtask

  // ---------------- directed stimulus ----------------
  int t0, wen0;
  initial begin
    RST = 1'b1; REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    ack_delay = 0; bank_rdata = '0; inject_ack = 1'b0;
    reset_dut();
    @(negedge CLK);
    chk("rst_done",  REQ_DONE, '0);
    chk("rst_addr",  REG_ADDR, '0);
    chk("rst_strobe", {REG_WEN, REG_REN}, 2'b00);
    chk("rst_state", dbg_state, IDLE);
    next_cycle();

    // Single read by req0, ACK in the strobe cycle.
    bank_rdata = 32'hA5A5_0001; ack_delay = 0;
    set_req(0, 1'b0, 8'h04, '0);
    t0 = cyc; exp_q.push_back(4'b0001);
    expect_done("rd0", t0 + 2, 32'hA5A5_0001, 1'b0, 8'h04);
    next_cycle(); REQ_VALID = '0;

    // All four held, zero-wait bank: grants 0,1,2,3,0 every 3 cycles.
    reset_dut();
    bank_rdata = 32'h0BAD_0002;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(8'h40 + i), '0);
    t0 = cyc;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100); exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    expect_done("rr0", t0 + 2,  32'h0BAD_0002, 1'b0, 8'h40);
    expect_done("rr1", t0 + 5,  32'h0BAD_0002, 1'b0, 8'h41);
    expect_done("rr2", t0 + 8,  32'h0BAD_0002, 1'b0, 8'h42);
    expect_done("rr3", t0 + 11, 32'h0BAD_0002, 1'b0, 8'h43);
    expect_done("rr4", t0 + 14, 32'h0BAD_0002, 1'b0, 8'h40);
    next_cycle(); REQ_VALID = '0;

    // Req2 write, ACK three cycles after the strobe.
    next_cycle();
    ack_delay = 3;
    set_req(2, 1'b1, 8'h10, 32'hDEAD_BEEF);
    t0 = cyc; wen0 = wen_total; exp_q.push_back(4'b0100);
    expect_done("wr2", t0 + 5, '0, 1'b0, 8'h10);
    chk("wr2_wen_cycles", 64'(wen_total - wen0), 64'd1);
    chk("wr2_wdata", REG_WDATA, 32'hDEAD_BEEF);
    next_cycle(); REQ_VALID = '0;

    // Timeout: bank ACKs one cycle too late (in the completion cycle).
    next_cycle();
    ack_delay = TO + 1; bank_rdata = 32'h0000_0077;
    set_req(1, 1'b0, 8'h22, '0);
    t0 = cyc; exp_q.push_back(4'b0010);
    expect_done("tmo", t0 + 2 + TO, '0, 1'b1, 8'h22);
    next_cycle(); REQ_VALID = '0; inject_ack = 1'b1;
    next_cycle(); inject_ack = 1'b0;
    ack_delay = 1; bank_rdata = 32'h1234_5678;
    set_req(3, 1'b0, 8'h33, '0);
    t0 = cyc; exp_q.push_back(4'b1000);
    expect_done("after_tmo", t0 + 3, 32'h1234_5678, 1'b0, 8'h33);
    next_cycle(); REQ_VALID = '0;

    // Reset while waiting on a silent bank.
    next_cycle();
    ack_delay = -1;
    set_req(0, 1'b0, 8'h55, '0);
    repeat (3) next_cycle();
    chk("pre_rst_state", dbg_state, WAIT);
    RST = 1'b1; REQ_VALID = '0;
    next_cycle(); RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_done", REQ_DONE, '0);
    chk("mid_rst_out", {REG_WEN, REG_REN, RSP_ERR, REG_ADDR, RSP_RDATA}, '0);
    next_cycle();
    ack_delay = 0; bank_rdata = 32'h0000_00C3;
    set_req(0, 1'b0, 8'h50, '0);
    set_req(3, 1'b0, 8'h53, '0);
    t0 = cyc; exp_q.push_back(4'b0001); exp_q.push_back(4'b1000);
    expect_done("post_rst0", t0 + 2, 32'h0000_00C3, 1'b0, 8'h50);
    expect_done("post_rst3", t0 + 5, 32'h0000_00C3, 1'b0, 8'h53);
    next_cycle(); REQ_VALID = '0;

    // Req1 drops VALID and changes ADDR after being granted.
    next_cycle();
    ack_delay = 2; bank_rdata = 32'hCAFE_0006;
    set_req(1, 1'b0, 8'h21, '0);
    t0 = cyc; exp_q.push_back(4'b0010);
    next_cycle();
    REQ_VALID[1] = 1'b0; REQ_ADDR[15:8] = 8'h99;
    expect_done("drop1", t0 + 4, 32'hCAFE_0006, 1'b0, 8'h21);

    repeat (3) next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=still running want=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
